instr_loader: RTL and testbench



---
 rtl/instr_loader_pkg.sv | 27 ++
 rtl/uart_rx_byte.sv | 107 ++++++++++
 rtl/instr_loader.sv | 137 +++++++++++++
 tb/tb_instr_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared widths, frame constants and FSM state types for the boot loader
package instr_loader_pkg;

    localparam int ADDR_WIDTH       = 32;
    localparam int INSTR_WIDTH      = 32;
    localparam int WORD_COUNT_WIDTH = 16;

    localparam logic [7:0] LOADER_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } load_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 serial byte receiver with input synchronizer
module uart_rx_byte
    import instr_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync_a;
    logic          sync_b;
    rx_state_t     state;
    rx_state_t     state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          cnt_clr;
    logic          sample_bit;
    logic          take_byte;
    logic          bad_stop;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= uart_rx;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        sample_bit = 1'b0;
        take_byte  = 1'b0;
        bad_stop   = 1'b0;
        case (state)
            R_IDLE: begin
                cnt_clr = 1'b1;
                if (!sync_b) state_next = R_START;
            end
            R_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = sync_b ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_clr    = 1'b1;
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) state_next = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_clr    = 1'b1;
                    take_byte  = sync_b;
                    bad_stop   = !sync_b;
                    state_next = R_IDLE;
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            cnt        <= cnt_clr ? '0 : cnt + 1'b1;
            byte_valid <= take_byte;
            frame_err  <= bad_stop;
            if (state == R_START) bit_idx <= 3'd0;
            if (sample_bit) begin
                shift   <= {sync_b, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (take_byte) byte_data <= shift;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - UART boot loader writing a framed program image into instruction memory
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 115200,
    parameter int MAX_WORDS = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        uart_rx,
    input  logic                        load_req,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [INSTR_WIDTH-1:0]      mem_wdata,
    output logic                        cpu_hold,
    output logic                        done,
    output logic                        error,
    output logic [WORD_COUNT_WIDTH-1:0] word_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;

    load_state_t state;
    load_state_t state_next;
    logic [8:0]  target;
    logic [8:0]  len_words;
    logic        len_ok;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;
    logic [23:0] wbuf;
    logic        word_last;
    logic        write_word;
    logic [WORD_COUNT_WIDTH-1:0] count_inc;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // A length byte of zero encodes 256 words; it only fits when the memory is that deep.
    always_comb begin
        len_words  = (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
        len_ok     = int'(len_words) <= MAX_WORDS;
        count_inc  = word_count + WORD_COUNT_WIDTH'(1);
        word_last  = (count_inc == WORD_COUNT_WIDTH'(target));
        write_word = (state == DATA) && byte_valid && (byte_idx == 2'd3) && load_req;
        cpu_hold   = (state != IDLE);
        done       = (state == DONE);
        error      = (state == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state != IDLE && !load_req) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (load_req) state_next = HDR;
                HDR: begin
                    if (frame_err) state_next = ERR;
                    else if (byte_valid && byte_data == LOADER_HEADER) state_next = LEN;
                end
                LEN: begin
                    if (frame_err) state_next = ERR;
                    else if (byte_valid) state_next = len_ok ? DATA : ERR;
                end
                DATA: begin
                    if (frame_err) state_next = ERR;
                    else if (write_word && word_last) state_next = CSUM;
                end
                CSUM: begin
                    if (frame_err) state_next = ERR;
                    else if (byte_valid) state_next = (byte_data == csum) ? DONE : ERR;
                end
                DONE, ERR: state_next = state;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            target     <= 9'd0;
            byte_idx   <= 2'd0;
            csum       <= 8'd0;
            wbuf       <= 24'd0;
        end else begin
            mem_we <= write_word;
            case (state)
                IDLE: begin
                    byte_idx <= 2'd0;
                    csum     <= 8'd0;
                    if (load_req) word_count <= '0;
                end
                LEN: if (byte_valid) target <= len_words;
                DATA: begin
                    if (byte_valid && load_req) begin
                        csum     <= csum ^ byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx != 2'd3) wbuf[{byte_idx, 3'b000} +: 8] <= byte_data;
                    end
                end
                default: ;
            endcase
            // Address uses the pre-increment count so word k lands at byte address 4*k.
            if (write_word) begin
                mem_addr   <= ADDR_WIDTH'({word_count, 2'b00});
                mem_wdata  <= {byte_data, wbuf};
                word_count <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized scoreboard bench for the UART boot loader
module tb_instr_loader;

    localparam int CPB = 10;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic        load_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        prev_we = 1'b0;

    instr_loader #(
        .CLK_FREQ (1000000),
        .BAUD     (100000),
        .MAX_WORDS(256)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .load_req  (load_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write and last one cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (exp_addr.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
            end else begin
                check("write_addr", mem_addr, exp_addr.pop_front());
                check("write_data", mem_wdata, exp_data.pop_front());
            end
        end
        prev_we = mem_we;
    end

    function automatic byte_q_t build_frame(input word_q_t words);
        byte_q_t f;
        logic [7:0] x;
        x = 8'd0;
        f.push_back(8'hA5);
        f.push_back(8'(words.size()));
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                f.push_back(words[i][8*k +: 8]);
                x ^= words[i][8*k +: 8];
            end
        end
        f.push_back(x);
        return f;
    endfunction

    task automatic expect_words(input word_q_t words);
        foreach (words[i]) begin
            exp_addr.push_back(32'(i * 4));
            exp_data.push_back(words[i]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input byte_q_t f);
        foreach (f[i]) send_byte(f[i], 1'b1);
    endtask

    task automatic start_session();
        @(negedge clk);
        load_req = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_session(input string tag);
        load_req = 1'b0;
        @(negedge clk);
        check({tag, "_idle_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_error"}, {31'd0, error}, 32'd0);
    endtask

    task automatic wait_status(input string tag, input bit exp_done, input bit exp_err, input int exp_wc);
        int t;
        t = 0;
        while (!(done || error) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_timeout"}, {31'd0, t < 400}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_word_count"}, {16'd0, word_count}, 32'(exp_wc));
        check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        word_q_t w;
        byte_q_t f;
        int rx_events;

        reset    = 1'b1;
        load_req = 1'b0;
        uart_rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_word_count", {16'd0, word_count}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Two-word reference program
        w = '{32'h00000013, 32'h005000B3};
        expect_words(w);
        start_session();
        check("hold_after_req", {31'd0, cpu_hold}, 32'd1);
        send_frame(build_frame(w));
        wait_status("two_word", 1'b1, 1'b0, 2);
        end_session("two_word");

        // Garbage before header is discarded
        w = '{32'h0000006F};
        expect_words(w);
        start_session();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_frame(build_frame(w));
        wait_status("garbage", 1'b1, 1'b0, 1);
        end_session("garbage");

        // Bad checksum: the word is still written, then error
        expect_words(w);
        f = build_frame(w);
        f[f.size() - 1] = 8'h00;
        start_session();
        send_frame(f);
        wait_status("bad_csum", 1'b0, 1'b1, 1);
        end_session("bad_csum");

        // Stop bit low on the third data byte
        w = '{$urandom, $urandom};
        f = build_frame(w);
        start_session();
        for (int i = 0; i < 4; i++) send_byte(f[i], 1'b1);
        send_byte(f[4], 1'b0);
        wait_status("frame_err", 1'b0, 1'b1, 0);
        for (int i = 5; i < f.size(); i++) send_byte(f[i], 1'b1);
        check("frame_err_held", {31'd0, error}, 32'd1);
        end_session("frame_err");

        // Abort after two bytes of word 0
        w = '{32'hDEADBEEF};
        f = build_frame(w);
        start_session();
        for (int i = 0; i < 4; i++) send_byte(f[i], 1'b1);
        load_req = 1'b0;
        @(negedge clk);
        check("abort_hold", {31'd0, cpu_hold}, 32'd0);
        check("abort_word_count", {16'd0, word_count}, 32'd0);
        for (int i = 4; i < f.size(); i++) send_byte(f[i], 1'b1);

        // Start-bit glitch while waiting for the header
        start_session();
        rx_events = 0;
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (15 * CPB) begin
            @(negedge clk);
            if (dut.u_rx.byte_valid || dut.u_rx.frame_err) rx_events++;
        end
        check("glitch_no_byte", 32'(rx_events), 32'd0);
        check("glitch_hold", {31'd0, cpu_hold}, 32'd1);
        check("glitch_error", {31'd0, error}, 32'd0);
        w = '{32'h12345678};
        expect_words(w);
        send_frame(build_frame(w));
        wait_status("post_glitch", 1'b1, 1'b0, 1);
        end_session("post_glitch");

        // Randomized sessions, each starting from address 0
        for (int s = 0; s < 4; s++) begin
            int n;
            int g;
            logic [7:0] gb;
            n = $urandom_range(1, 5);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            expect_words(w);
            start_session();
            g = $urandom_range(0, 2);
            for (int i = 0; i < g; i++) begin
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h5A;
                send_byte(gb, 1'b1);
            end
            send_frame(build_frame(w));
            wait_status($sformatf("rand%0d", s), 1'b1, 1'b0, n);
            end_session($sformatf("rand%0d", s));
        end

        // Reset in the middle of DATA
        w = '{32'h00000013, 32'h005000B3};
        f = build_frame(w);
        exp_addr.push_back(32'd0);
        exp_data.push_back(32'h00000013);
        start_session();
        for (int i = 0; i < 7; i++) send_byte(f[i], 1'b1);
        check("pre_reset_word_count", {16'd0, word_count}, 32'd1);
        check("pre_reset_wdata", mem_wdata, 32'h00000013);
        reset = 1'b1;
        load_req = 1'b0;
        @(negedge clk);
        check("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_mem_wdata", mem_wdata, 32'd0);
        check("mid_rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("mid_rst_word_count", {16'd0, word_count}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_error", {31'd0, error}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        check("scoreboard_drained", 32'(exp_addr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
